// File: rtl/scene_pkg.sv
// Shared scene definitions: entity word layout, slot count and display timing
// constants used by the scene latch and the sync generator.
package scene_pkg;

    localparam int NUM_SLOTS = 9;
    localparam int ENTITY_W  = 14;
    localparam int SLOT_W    = 4;
    localparam int CNT_W     = 10;

    typedef logic [ENTITY_W-1:0] entity_t;
    typedef logic [SLOT_W-1:0]   slot_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    // Field offsets within an entity word.
    localparam int ID_MSB     = 13;
    localparam int ID_LSB     = 10;
    localparam int ORIENT_MSB = 9;
    localparam int ORIENT_LSB = 8;
    localparam int TILE_MSB   = 7;
    localparam int TILE_LSB   = 0;

    localparam entity_t EMPTY_ENTITY = 14'h3FFF;

    localparam cnt_t V_VISIBLE = 10'd480;
    localparam cnt_t H_VISIBLE = 10'd640;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } latch_state_t;

    function automatic logic slot_is_valid(input slot_t slot);
        return slot < slot_t'(NUM_SLOTS);
    endfunction

endpackage

// File: rtl/vblank_event_detect.sv
// Flags the cycle in which the sync counters sit on the first blanking line,
// column zero. Combinational so the event can be acted on at that cycle's edge.
module vblank_event_detect
    import scene_pkg::*;
#(
    parameter cnt_t V_MATCH = V_VISIBLE,
    parameter cnt_t H_MATCH = '0
) (
    input  logic [CNT_W-1:0] counter_V,
    input  logic [CNT_W-1:0] counter_H,
    output logic             o_event
);

    assign o_event = (counter_V == V_MATCH) && (counter_H == H_MATCH);

endmodule

// File: rtl/entity_scene_latch.sv
// Double-buffered entity scene: game logic fills a shadow bank, and a commit
// copies it to the active bank at the next vblank start.
module entity_scene_latch
    import scene_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [SLOT_W-1:0]   wr_slot,
    input  logic [ENTITY_W-1:0] wr_data,
    input  logic                commit_req,
    output logic                commit_pending,
    output logic                frame_swapped,
    output logic                bad_slot,
    input  logic [CNT_W-1:0]    counter_V,
    input  logic [CNT_W-1:0]    counter_H,
    output logic [ENTITY_W-1:0] entity_1,
    output logic [ENTITY_W-1:0] entity_2,
    output logic [ENTITY_W-1:0] entity_3,
    output logic [ENTITY_W-1:0] entity_4,
    output logic [ENTITY_W-1:0] entity_5,
    output logic [ENTITY_W-1:0] entity_6,
    output logic [ENTITY_W-1:0] entity_7,
    output logic [ENTITY_W-1:0] entity_8_Flip,
    output logic [ENTITY_W-1:0] entity_9_Flip
);

    latch_state_t r_state;
    latch_state_t w_state_next;
    entity_t      r_shadow [NUM_SLOTS];
    entity_t      r_active [NUM_SLOTS];
    logic         r_frame_swapped;
    logic         r_bad_slot;
    logic         w_vblank;
    logic         w_wr_fire;
    logic         w_swap;

    vblank_event_detect #(
        .V_MATCH (V_VISIBLE),
        .H_MATCH ('0)
    ) u_vblank (
        .counter_V (counter_V),
        .counter_H (counter_H),
        .o_event   (w_vblank)
    );

    assign wr_ready       = (r_state == ST_IDLE);
    assign commit_pending = (r_state == ST_PENDING);
    assign w_wr_fire      = wr_valid && wr_ready;
    assign w_swap         = (r_state == ST_PENDING) && w_vblank;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (commit_req) w_state_next = ST_PENDING;
            ST_PENDING: if (w_vblank)   w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: both banks are flops, not RAM, so they are cleared on reset like any other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_frame_swapped <= 1'b0;
            r_bad_slot      <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_shadow[i] <= EMPTY_ENTITY;
                r_active[i] <= EMPTY_ENTITY;
            end
        end else begin
            r_state         <= w_state_next;
            r_frame_swapped <= w_swap;
            r_bad_slot      <= w_wr_fire && !slot_is_valid(wr_slot);
            // A write alongside commit_req lands here before the bank freezes.
            if (w_wr_fire && slot_is_valid(wr_slot)) begin
                r_shadow[wr_slot] <= wr_data;
            end
            if (w_swap) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    assign frame_swapped = r_frame_swapped;
    assign bad_slot      = r_bad_slot;

    assign entity_1      = r_active[0];
    assign entity_2      = r_active[1];
    assign entity_3      = r_active[2];
    assign entity_4      = r_active[3];
    assign entity_5      = r_active[4];
    assign entity_6      = r_active[5];
    assign entity_7      = r_active[6];
    assign entity_8_Flip = r_active[7];
    assign entity_9_Flip = r_active[8];

endmodule

// File: tb/tb_entity_scene_latch.sv
// Directed bench for entity_scene_latch: reset, commit/vblank swap, frozen
// shadow while pending, invalid slots, commit on the event cycle, reset while pending.
module tb_entity_scene_latch;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_slot;
    logic [13:0] wr_data;
    logic        commit_req;
    logic        commit_pending;
    logic        frame_swapped;
    logic        bad_slot;
    logic [9:0]  counter_V;
    logic [9:0]  counter_H;
    logic [13:0] ent [9];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    entity_scene_latch dut (
        .clk            (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_slot        (wr_slot),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .frame_swapped  (frame_swapped),
        .bad_slot       (bad_slot),
        .counter_V      (counter_V),
        .counter_H      (counter_H),
        .entity_1       (ent[0]),
        .entity_2       (ent[1]),
        .entity_3       (ent[2]),
        .entity_4       (ent[3]),
        .entity_5       (ent[4]),
        .entity_6       (ent[5]),
        .entity_7       (ent[6]),
        .entity_8_Flip  (ent[7]),
        .entity_9_Flip  (ent[8])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [3:0] slot, input logic [13:0] data, input logic with_commit);
        wr_valid   = 1'b1;
        wr_slot    = slot;
        wr_data    = data;
        commit_req = with_commit;
        tick();
        wr_valid   = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic vblank();
        counter_V = 10'd480;
        counter_H = 10'd0;
        tick();
        counter_V = 10'd100;
        counter_H = 10'd5;
    endtask

    task automatic check_scene(input string tag, input logic [13:0] exp [9]);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_slot%0d", tag, i), 32'(ent[i]), 32'(exp[i]));
        end
    endtask

    logic [13:0] empty_scene [9];
    logic [13:0] exp_scene   [9];

    initial begin
        for (int i = 0; i < 9; i++) empty_scene[i] = 14'h3FFF;
        reset      = 1'b1;
        wr_valid   = 1'b0;
        wr_slot    = '0;
        wr_data    = '0;
        commit_req = 1'b0;
        counter_V  = 10'd100;
        counter_H  = 10'd5;

        // 1. Reset
        tick(2);
        reset = 1'b0;
        check_scene("reset", empty_scene);
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_pending", 32'(commit_pending), 32'd0);
        check("reset_swapped", 32'(frame_swapped), 32'd0);
        check("reset_bad_slot", 32'(bad_slot), 32'd0);

        // 2. Commit of slot 0, held until the vblank event
        write(4'd0, 14'h0A05, 1'b0);
        commit();
        check("t2_pending", 32'(commit_pending), 32'd1);
        check("t2_ready_low", 32'(wr_ready), 32'd0);
        check("t2_ent1_hold", 32'(ent[0]), 32'h3FFF);
        counter_V = 10'd480; counter_H = 10'd1;   // right line, wrong column
        tick();
        counter_V = 10'd479; counter_H = 10'd0;   // right column, wrong line
        tick(3);
        counter_V = 10'd100; counter_H = 10'd5;
        check("t2_ent1_near", 32'(ent[0]), 32'h3FFF);
        check("t2_pending_near", 32'(commit_pending), 32'd1);
        check("t2_swapped_early", 32'(frame_swapped), 32'd0);
        vblank();
        check("t2_ent1_new", 32'(ent[0]), 32'h0A05);
        check("t2_swapped", 32'(frame_swapped), 32'd1);
        check("t2_pending_clr", 32'(commit_pending), 32'd0);
        tick();
        check("t2_swapped_pulse", 32'(frame_swapped), 32'd0);

        // 3. Writes while pending are blocked; shadow stays frozen
        commit();
        wr_valid = 1'b1; wr_slot = 4'd3; wr_data = 14'h0BAD;
        check("t3_ready_low", 32'(wr_ready), 32'd0);
        tick(2);
        wr_valid = 1'b0;
        vblank();
        check("t3_ent4_frozen", 32'(ent[3]), 32'h3FFF);
        check("t3_swapped", 32'(frame_swapped), 32'd1);
        write(4'd3, 14'h1234, 1'b0);
        tick(2);
        check("t3_ent4_no_commit", 32'(ent[3]), 32'h3FFF);
        commit();
        check("t3_ent4_pending", 32'(ent[3]), 32'h3FFF);
        vblank();
        check("t3_ent4_new", 32'(ent[3]), 32'h1234);

        // 4. Same-cycle write + commit, then invalid slots
        write(4'd8, 14'h2233, 1'b1);
        check("t4_pending", 32'(commit_pending), 32'd1);
        vblank();
        check("t4_ent9", 32'(ent[8]), 32'h2233);
        write(4'd12, 14'h0000, 1'b0);
        check("t4_bad_slot12", 32'(bad_slot), 32'd1);
        check("t4_ready", 32'(wr_ready), 32'd1);
        tick();
        check("t4_bad_slot_pulse", 32'(bad_slot), 32'd0);
        write(4'd9, 14'h0000, 1'b0);
        check("t4_bad_slot9", 32'(bad_slot), 32'd1);
        write(4'd8, 14'h2233, 1'b0);
        check("t4_slot8_valid", 32'(bad_slot), 32'd0);
        commit();
        vblank();
        for (int i = 0; i < 9; i++) exp_scene[i] = 14'h3FFF;
        exp_scene[0] = 14'h0A05;
        exp_scene[3] = 14'h1234;
        exp_scene[8] = 14'h2233;
        check_scene("t4_scene", exp_scene);

        // 5. Commit on the event cycle swaps only at the next frame
        write(4'd1, 14'h0111, 1'b0);
        counter_V = 10'd480; counter_H = 10'd0; commit_req = 1'b1;
        tick();
        commit_req = 1'b0; counter_V = 10'd100; counter_H = 10'd5;
        check("t5_no_same_swap", 32'(ent[1]), 32'h3FFF);
        check("t5_no_swapped", 32'(frame_swapped), 32'd0);
        check("t5_pending", 32'(commit_pending), 32'd1);
        tick(3);
        vblank();
        check("t5_ent2_new", 32'(ent[1]), 32'h0111);
        check("t5_swapped", 32'(frame_swapped), 32'd1);

        // 6. Reset while pending discards the swap and clears both banks
        write(4'd2, 14'h0222, 1'b1);
        check("t6_pending", 32'(commit_pending), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_scene("t6_reset", empty_scene);
        check("t6_pending_clr", 32'(commit_pending), 32'd0);
        check("t6_ready", 32'(wr_ready), 32'd1);
        vblank();
        check("t6_no_swap", 32'(frame_swapped), 32'd0);
        check("t6_ent3", 32'(ent[2]), 32'h3FFF);
        commit();
        vblank();
        check("t6_swap_after_reset", 32'(frame_swapped), 32'd1);
        check_scene("t6_shadow_cleared", empty_scene);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
